cci_mpf_rd_credit_arb: RTL and testbench

// - Round-robin scheduler sharing one FIU read channel (c0) among N_REQ

---
 rtl/cci_mpf_rd_credit_arb.sv | 152 +++++++++++++++
 tb/tb_cci_mpf_rd_credit_arb.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cci_mpf_rd_credit_arb.sv
// Round-robin arbiter sharing the FIU c0 read channel among N_REQ requesters,
// with per-requester and global outstanding-read credits and a drain handshake.
module cci_mpf_rd_credit_arb #(
  parameter  int N_REQ       = 4,
  parameter  int MAX_PER_REQ = 64,
  parameter  int MAX_TOTAL   = 128,
  localparam int IDW         = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CNT_W       = $clog2(MAX_PER_REQ + 1),
  localparam int TOT_W       = $clog2(MAX_TOTAL + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] req_ready,
  input  logic             c0_almost_full,
  output logic             out_valid,
  output logic [IDW-1:0]   out_id,
  input  logic             rsp_valid,
  input  logic [IDW-1:0]   rsp_id,
  input  logic             drain_req,
  output logic             drain_ack,
  output logic [N_REQ-1:0] not_empty,
  output logic [TOT_W-1:0] total_active,
  output logic             err_underflow
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [TOT_W-1:0] total_reg;
  logic [IDW-1:0]   rr_ptr_reg;
  logic             out_valid_reg;
  logic [IDW-1:0]   out_id_reg;
  logic             err_reg;

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] rsp_dec;
  logic             arb_open;
  logic             grant_any;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   cand_idx;
  logic             total_dec;
  logic             underflow_evt;

  // Global gates: a drain request blocks grants in the very cycle it appears.
  assign arb_open = !reset && (state_reg == ST_RUN) && !drain_req &&
                    !c0_almost_full && (total_reg < TOT_W'(MAX_TOTAL));

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    logic [CNT_W-1:0] cnt_reg;
    logic             rsp_hit;

    assign rsp_hit      = rsp_valid && (rsp_id == IDW'(gi));
    assign rsp_dec[gi]  = rsp_hit && (cnt_reg != '0);
    assign eligible[gi] = arb_open && req_valid[gi] &&
                          (cnt_reg < CNT_W'(MAX_PER_REQ));
    assign grant[gi]    = grant_any && (grant_idx == IDW'(gi));
    assign not_empty[gi] = (cnt_reg != '0);

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_reg <= '0;
      end else if (grant[gi] && !rsp_dec[gi]) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end else if (!grant[gi] && rsp_dec[gi]) begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
    end
  end

  // rr_ptr_reg holds the highest-priority index for the next search.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_idx = IDW'((int'(rr_ptr_reg) + k) % N_REQ);
      if (!grant_any && eligible[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  assign req_ready = grant;

  // A response to an idle requester (or an out-of-range id) returns no credit.
  assign total_dec     = |rsp_dec;
  assign underflow_evt = rsp_valid && !total_dec;

  always_ff @(posedge clk) begin
    if (reset) begin
      total_reg     <= '0;
      rr_ptr_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_id_reg    <= '0;
      err_reg       <= 1'b0;
      state_reg     <= ST_RUN;
    end else begin
      if (grant_any && !total_dec) begin
        total_reg <= total_reg + TOT_W'(1);
      end else if (!grant_any && total_dec) begin
        total_reg <= total_reg - TOT_W'(1);
      end
      out_valid_reg <= grant_any;
      if (grant_any) begin
        out_id_reg <= grant_idx;
        rr_ptr_reg <= (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + IDW'(1);
      end
      if (underflow_evt) begin
        err_reg <= 1'b1;
      end
      state_reg <= state_next;
    end
  end

  // The registered issue strobe is checked so a read granted on the last
  // cycle before drain is still seen as in flight.
  always_comb begin
    state_next = state_reg;
    drain_ack  = 1'b0;
    unique case (state_reg)
      ST_RUN: begin
        if (drain_req) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!drain_req) begin
          state_next = ST_RUN;
        end else if ((total_reg == '0) && !out_valid_reg) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        drain_ack = 1'b1;
        if (!drain_req) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  assign out_valid     = out_valid_reg;
  assign out_id        = out_id_reg;
  assign total_active  = total_reg;
  assign err_underflow = err_reg;

endmodule

// File: tb/tb_cci_mpf_rd_credit_arb.sv
// Self-checking bench for cci_mpf_rd_credit_arb: directed scenarios plus a
// randomized run compared against a credit/round-robin reference model.
module tb_cci_mpf_rd_credit_arb;

  localparam int N     = 4;
  localparam int MAXP  = 64;
  localparam int MAXT  = 128;
  localparam int IDW   = 2;
  localparam int TOT_W = 8;
  localparam int M_RUN = 0, M_DRAIN = 1, M_DONE = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic             c0_almost_full;
  logic             out_valid;
  logic [IDW-1:0]   out_id;
  logic             rsp_valid;
  logic [IDW-1:0]   rsp_id;
  logic             drain_req;
  logic             drain_ack;
  logic [N-1:0]     not_empty;
  logic [TOT_W-1:0] total_active;
  logic             err_underflow;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_cnt [N];
  int m_total;
  int m_next;
  int m_state;
  bit m_ov;
  int m_oid;
  bit m_err;

  cci_mpf_rd_credit_arb #(.N_REQ(N), .MAX_PER_REQ(MAXP), .MAX_TOTAL(MAXT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .c0_almost_full(c0_almost_full), .out_valid(out_valid), .out_id(out_id),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .drain_req(drain_req),
    .drain_ack(drain_ack), .not_empty(not_empty), .total_active(total_active),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  function automatic int model_grant();
    logic [IDW-1:0] ix;
    if (reset || m_state != M_RUN || drain_req || c0_almost_full || m_total >= MAXT)
      return -1;
    for (int k = 0; k < N; k++) begin
      ix = IDW'((m_next + k) % N);
      if (req_valid[ix] && m_cnt[ix] < MAXP) return int'(ix);
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = model_grant();
    if (g >= 0) r[IDW'(g)] = 1'b1;
    return r;
  endfunction

  function automatic logic [N-1:0] exp_not_empty();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[IDW'(i)] = (m_cnt[IDW'(i)] != 0);
    return r;
  endfunction

  // Advance the model with the inputs currently applied, then let the DUT clock.
  task automatic tick();
    int g;
    logic [IDW-1:0] rid;
    bit dec;
    if (reset) begin
      for (int i = 0; i < N; i++) m_cnt[IDW'(i)] = 0;
      m_total = 0; m_next = 0; m_state = M_RUN; m_ov = 0; m_oid = 0; m_err = 0;
    end else begin
      g   = model_grant();
      rid = rsp_id;
      dec = rsp_valid && (m_cnt[rid] > 0);
      if (rsp_valid && !dec) m_err = 1'b1;
      case (m_state)
        M_RUN:   if (drain_req) m_state = M_DRAIN;
        M_DRAIN: if (!drain_req) m_state = M_RUN;
                 else if (m_total == 0 && !m_ov) m_state = M_DONE;
        default: if (!drain_req) m_state = M_RUN;
      endcase
      m_ov = (g >= 0);
      if (g >= 0) begin
        m_cnt[IDW'(g)]++;
        m_total++;
        m_next = (g + 1) % N;
        m_oid  = g;
      end
      if (dec) begin
        m_cnt[rid]--;
        m_total--;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; c0_almost_full = 1'b0;
    rsp_valid = 1'b0; rsp_id = '0; drain_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '1; c0_almost_full = 1'b0;
    rsp_valid = 1'b0; rsp_id = '0; drain_req = 1'b0;
    #1;
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
    tick();
    tick();
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL reset_ready2 got=%b exp=0", req_ready); end
    checks++;
    if ({out_valid, out_id, drain_ack, not_empty, err_underflow} !== '0) begin
      errors++;
      $display("FAIL reset_outs ov=%b id=%0d ack=%b ne=%b err=%b exp all 0",
               out_valid, out_id, drain_ack, not_empty, err_underflow);
    end
    checks++;
    if (total_active !== '0) begin errors++; $display("FAIL reset_total got=%0d exp=0", total_active); end
    reset = 1'b0; req_valid = '0;
    $display("test_reset done");
  endtask

  task automatic test_rr_fill();
    logic [N-1:0] exp;
    do_reset();
    req_valid = '1;
    for (int c = 0; c < MAXT + 4; c++) begin
      #1;
      exp = (c < MAXT) ? N'(1 << (c % N)) : '0;
      checks++;
      if (req_ready !== exp) begin errors++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, exp); end
      tick();
      checks++;
      if (out_valid !== (c < MAXT) || (c < MAXT && out_id !== IDW'(c % N))) begin
        errors++;
        $display("FAIL rr_issue c=%0d got ov=%b id=%0d exp ov=%b id=%0d", c, out_valid, out_id, c < MAXT, c % N);
      end
    end
    checks++;
    if (total_active !== TOT_W'(MAXT) || not_empty !== '1) begin
      errors++;
      $display("FAIL rr_full total=%0d ne=%b exp total=%0d ne=1111", total_active, not_empty, MAXT);
    end
    req_valid = '0;
    $display("test_rr_fill done");
  endtask

  task automatic test_per_req_limit();
    do_reset();
    req_valid = 4'b0001;
    for (int c = 0; c < MAXP + 2; c++) begin
      #1;
      checks++;
      if (req_ready !== ((c < MAXP) ? 4'b0001 : 4'b0000)) begin
        errors++; $display("FAIL per_req_ready c=%0d got=%b exp=%b", c, req_ready, c < MAXP);
      end
      tick();
    end
    checks++;
    if (total_active !== TOT_W'(MAXP)) begin errors++; $display("FAIL per_req_total got=%0d exp=%0d", total_active, MAXP); end
    rsp_valid = 1'b1; rsp_id = 2'd0;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL per_req_same_cycle got=%b exp=0000", req_ready); end
    tick();
    rsp_valid = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL per_req_resume got=%b exp=0001", req_ready); end
    tick();
    checks++;
    if (total_active !== TOT_W'(MAXP) || out_valid !== 1'b1) begin
      errors++; $display("FAIL per_req_after total=%0d ov=%b exp total=%0d ov=1", total_active, out_valid, MAXP);
    end
    req_valid = '0;
    $display("test_per_req_limit done");
  endtask

  task automatic test_almost_full();
    do_reset();
    req_valid = '1;
    for (int c = 0; c < 6; c++) tick();
    c0_almost_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (req_ready !== '0) begin errors++; $display("FAIL af_ready c=%0d got=%b exp=0000", c, req_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL af_out_valid c=%0d got=%b exp=0", c, out_valid); end
    end
    c0_almost_full = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL af_resume got=%b exp=0100", req_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_id !== 2'd2) begin
      errors++; $display("FAIL af_issue got ov=%b id=%0d exp ov=1 id=2", out_valid, out_id);
    end
    req_valid = '0;
    $display("test_almost_full done");
  endtask

  task automatic test_same_cycle();
    do_reset();
    req_valid = 4'b0100;
    for (int c = 0; c < 3; c++) tick();
    req_valid = '0;
    tick();
    req_valid = 4'b0100; rsp_valid = 1'b1; rsp_id = 2'd2;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL same_ready got=%b exp=0100", req_ready); end
    tick();
    req_valid = '0; rsp_valid = 1'b0;
    checks++;
    if (total_active !== 8'd3 || not_empty !== 4'b0100 || err_underflow !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle total=%0d ne=%b err=%b exp total=3 ne=0100 err=0", total_active, not_empty, err_underflow);
    end
    rsp_valid = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    rsp_valid = 1'b0;
    checks++;
    if (total_active !== 8'd0 || not_empty !== 4'b0000 || err_underflow !== 1'b0) begin
      errors++;
      $display("FAIL same_return total=%0d ne=%b err=%b exp total=0 ne=0000 err=0", total_active, not_empty, err_underflow);
    end
    $display("test_same_cycle done");
  endtask

  task automatic test_drain();
    logic [IDW-1:0] pick;
    do_reset();
    req_valid = '1;
    for (int c = 0; c < 10; c++) tick();
    drain_req = 1'b1;
    #1;
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL drain_block got=%b exp=0000", req_ready); end
    tick();
    for (int r = 0; r < 10; r++) begin
      pick = '0;
      for (int i = N - 1; i >= 0; i--) if (m_cnt[IDW'(i)] > 0) pick = IDW'(i);
      rsp_valid = 1'b1; rsp_id = pick;
      #1;
      checks++;
      if (req_ready !== '0 || drain_ack !== 1'b0) begin
        errors++; $display("FAIL drain_wait r=%0d ready=%b ack=%b exp 0000/0", r, req_ready, drain_ack);
      end
      tick();
    end
    rsp_valid = 1'b0;
    tick();
    checks++;
    if (drain_ack !== 1'b1 || total_active !== '0) begin
      errors++; $display("FAIL drain_ack got ack=%b total=%0d exp ack=1 total=0", drain_ack, total_active);
    end
    drain_req = 1'b0;
    #1;
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL drain_done_block got=%b exp=0000", req_ready); end
    tick();
    checks++;
    if (drain_ack !== 1'b0) begin errors++; $display("FAIL drain_ack_drop got=%b exp=0", drain_ack); end
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL drain_resume got=%b exp=0100", req_ready); end
    tick();
    req_valid = '0;
    $display("test_drain done");
  endtask

  task automatic test_underflow();
    do_reset();
    req_valid = 4'b0001;
    tick();
    tick();
    req_valid = '0;
    rsp_valid = 1'b1; rsp_id = 2'd1;
    tick();
    rsp_valid = 1'b0;
    checks++;
    if (err_underflow !== 1'b1 || total_active !== 8'd2 || not_empty !== 4'b0001) begin
      errors++;
      $display("FAIL underflow got err=%b total=%0d ne=%b exp err=1 total=2 ne=0001", err_underflow, total_active, not_empty);
    end
    for (int c = 0; c < 3; c++) tick();
    checks++;
    if (err_underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky got=%b exp=1", err_underflow); end
    do_reset();
    checks++;
    if (err_underflow !== 1'b0 || total_active !== '0) begin
      errors++; $display("FAIL underflow_reset got err=%b total=%0d exp 0/0", err_underflow, total_active);
    end
    rsp_valid = 1'b1; rsp_id = 2'd0;
    tick();
    rsp_valid = 1'b0;
    checks++;
    if (err_underflow !== 1'b1 || total_active !== '0) begin
      errors++; $display("FAIL underflow_inflight got err=%b total=%0d exp 1/0", err_underflow, total_active);
    end
    $display("test_underflow done");
  endtask

  task automatic test_random();
    logic [N-1:0] exp;
    logic [IDW-1:0] pick;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset          = ($urandom_range(999, 0) == 0);
      req_valid      = N'($urandom);
      c0_almost_full = ($urandom_range(7, 0) == 0);
      if ($urandom_range(63, 0) == 0) drain_req = ~drain_req;
      rsp_valid = ($urandom_range(9, 0) < 4);
      pick = IDW'($urandom_range(N - 1, 0));
      if ($urandom_range(15, 0) != 0)
        for (int i = 0; i < N; i++) if (m_cnt[IDW'(i)] > 0 && $urandom_range(1, 0) == 0) pick = IDW'(i);
      rsp_id = pick;
      #1;
      exp = exp_ready();
      checks++;
      if (req_ready !== exp) begin errors++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, exp); end
      tick();
      checks++;
      if (out_valid !== m_ov || out_id !== IDW'(m_oid)) begin
        errors++; $display("FAIL rand_issue c=%0d got ov=%b id=%0d exp ov=%b id=%0d", c, out_valid, out_id, m_ov, m_oid);
      end
      checks++;
      if (total_active !== TOT_W'(m_total) || not_empty !== exp_not_empty()) begin
        errors++;
        $display("FAIL rand_credit c=%0d got total=%0d ne=%b exp total=%0d ne=%b", c, total_active, not_empty, m_total, exp_not_empty());
      end
      checks++;
      if (drain_ack !== (m_state == M_DONE) || err_underflow !== m_err) begin
        errors++;
        $display("FAIL rand_status c=%0d got ack=%b err=%b exp ack=%b err=%b", c, drain_ack, err_underflow, m_state == M_DONE, m_err);
      end
    end
    reset = 1'b0; drain_req = 1'b0; rsp_valid = 1'b0; req_valid = '0;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_rr_fill();
    test_per_req_limit();
    test_almost_full();
    test_same_cycle();
    test_drain();
    test_underflow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
